tff_toggle_monitor: RTL and testbench

Downstream consumer of the T flip-flop output Q. Samples Q, detects rising and falling transitions, and counts them over a programmable window of clock cycles. Reports the rise/fall counts and an overflow flag through a valid/ready result handshake. Used to check toggle activity and frequency-divide ratios of T-flip-flop stages.

---
 rtl/tff_toggle_monitor.sv | 166 ++++++++++++++++
 tb/tb_tff_toggle_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_monitor.sv
// ============================================================================
// Module   : tff_toggle_monitor
// Purpose  : Watches the Q output of a T flip-flop stage, detects rising and
//            falling transitions, and counts them over a programmable window
//            of clock cycles. The rise/fall counts and an overflow flag are
//            returned through a valid/ready result handshake.
// Options  : TFF_MON_SYNC_EN - when defined, q_in_i passes through a 2-flop
//            synchronizer before edge detection, so q_in_i may be
//            asynchronous to clk. Detected edges then lag q_in_i by 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_toggle_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             q_in_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] rise_cnt_o,
    output logic [CNT_W-1:0] fall_cnt_o,
    output logic             ovf_o,
    output logic             res_valid_o,
    input  logic             res_ready_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [CNT_W-1:0] rise_cnt_q;
    logic [CNT_W-1:0] fall_cnt_q;
    logic             ovf_q;
    logic [WIN_W-1:0] win_q;
    logic             q_prev_q;

    logic             q_s;
    logic             rise_w;
    logic             fall_w;

`ifdef TFF_MON_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for an upstream Q that is not clocked by clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], q_in_i};
        end
    end

    assign q_s = sync_q[1];
`else
    assign q_s = q_in_i;
`endif

    // Previous sample of Q, tracked in every state so edge detection is
    // always primed when a window opens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_prev_q <= 1'b0;
        end else begin
            q_prev_q <= q_s;
        end
    end

    assign rise_w = q_s & ~q_prev_q;
    assign fall_w = ~q_s & q_prev_q;

    // Measurement FSM: capture window, count edges with saturation, then
    // hold the result until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            win_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rise_cnt_q <= '0;
                        fall_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        if (win_len_i == '0) begin
                            // Empty window: report a zero result right away.
                            state_q     <= S_REPORT;
                            res_valid_q <= 1'b1;
                        end else begin
                            win_q   <= win_len_i;
                            state_q <= S_COUNT;
                        end
                    end
                end

                S_COUNT: begin
                    if (win_q == '0) begin
                        // Last counted cycle was the one that drained the
                        // window counter; the result is now final.
                        state_q     <= S_REPORT;
                        res_valid_q <= 1'b1;
                    end else begin
                        win_q <= win_q - WIN_ONE;
                        if (rise_w) begin
                            if (rise_cnt_q == CNT_MAX) begin
                                ovf_q <= 1'b1;
                            end else begin
                                rise_cnt_q <= rise_cnt_q + CNT_ONE;
                            end
                        end
                        if (fall_w) begin
                            if (fall_cnt_q == CNT_MAX) begin
                                ovf_q <= 1'b1;
                            end else begin
                                fall_cnt_q <= fall_cnt_q + CNT_ONE;
                            end
                        end
                    end
                end

                S_REPORT: begin
                    // A start arriving with the handshake is dropped: the
                    // FSM is not in IDLE during this cycle.
                    if (res_ready_i) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign rise_cnt_o  = rise_cnt_q;
    assign fall_cnt_o  = fall_cnt_q;
    assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tff_toggle_monitor.sv
// ============================================================================
// Module   : tb_tff_toggle_monitor
// Purpose  : Self-checking bench for tff_toggle_monitor. A transaction-level
//            model records every sampled Q value and derives the expected
//            counts by scanning that history over the measurement window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tff_toggle_monitor;

    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef TFF_MON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [WIN_W-1:0] win_len_i;
    logic             q_in_i;
    logic             busy_o;
    logic [CNT_W-1:0] rise_cnt_o;
    logic [CNT_W-1:0] fall_cnt_o;
    logic             ovf_o;
    logic             res_valid_o;
    logic             res_ready_i;

    int n_vec = 0;
    int n_bad = 0;
    int qmode = 0;  // 0 hold, 1 toggle every cycle, 2 random

    tff_toggle_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .win_len_i  (win_len_i),
        .q_in_i     (q_in_i),
        .busy_o     (busy_o),
        .rise_cnt_o (rise_cnt_o),
        .fall_cnt_o (fall_cnt_o),
        .ovf_o      (ovf_o),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit samp[$];     // q_in_i seen at edge e is samp[e-1]
    int e_n;         // edges since reset release
    int ph;          // 0 idle, 1 measuring, 2 reporting
    int k_e, w_e;    // accept edge and window length
    int m_rise, m_fall;
    bit m_ovf;

    function automatic bit qs(int e);
        int i;
        i = e - LAT;
        if (i < 1) return 1'b0;
        return samp[i-1];
    endfunction

    task automatic tally(int a, int b);
        int r, f;
        r = 0;
        f = 0;
        for (int e = a; e <= b; e++) begin
            if (qs(e) && !qs(e - 1)) r++;
            if (!qs(e) && qs(e - 1)) f++;
        end
        m_rise = (r > MAXC) ? MAXC : r;
        m_fall = (f > MAXC) ? MAXC : f;
        m_ovf  = (r > MAXC) || (f > MAXC);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            samp.delete();
            e_n = 0; ph = 0; k_e = 0; w_e = 0;
            m_rise = 0; m_fall = 0; m_ovf = 1'b0;
        end else begin
            e_n++;
            samp.push_back(q_in_i);
            case (ph)
                0: if (start_i) begin
                    m_rise = 0; m_fall = 0; m_ovf = 1'b0;
                    if (win_len_i == 0) ph = 2;
                    else begin ph = 1; k_e = e_n; w_e = int'(win_len_i); end
                end
                1: if (e_n <= k_e + w_e) tally(k_e + 1, e_n);
                   else ph = 2;
                default: if (res_ready_i) ph = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            n_vec++;
            if (busy_o !== (ph != 0) || res_valid_o !== (ph == 2) ||
                rise_cnt_o !== CNT_W'(m_rise) || fall_cnt_o !== CNT_W'(m_fall) ||
                ovf_o !== m_ovf) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t: got busy=%b vld=%b rise=%0d fall=%0d ovf=%b want busy=%b vld=%b rise=%0d fall=%0d ovf=%b",
                         $time, busy_o, res_valid_o, rise_cnt_o, fall_cnt_o, ovf_o,
                         ph != 0, ph == 2, m_rise, m_fall, m_ovf);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
        case (qmode)
            1:       q_in_i = ~q_in_i;
            2:       q_in_i = 1'($urandom);
            default: q_in_i = q_in_i;
        endcase
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (res_valid_o !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_valid: got timeout want res_valid");
        end
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, busy_o, res_valid_o, ovf_o, rise_cnt_o, fall_cnt_o};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; start_i = 1'b0; win_len_i = '0; q_in_i = 1'b0; res_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (20) cyc();
        lit("idle_after_reset", outs(), 32'd0);

        // Toggling Q, 10-cycle window
        qmode = 1;
        repeat (4) cyc();
        start_i = 1'b1; win_len_i = 16'd10;
        cyc();
        start_i = 1'b0; win_len_i = 16'(2 + $urandom_range(0, 50));
        wait_valid(n);
        lit("valid_latency", 32'(n), 32'd11);
        lit("toggle_rise", 32'(rise_cnt_o), 32'd5);
        lit("toggle_fall", 32'(fall_cnt_o), 32'd5);
        lit("toggle_ovf", 32'(ovf_o), 32'd0);

        // Start during REPORT is ignored
        start_i = 1'b1; win_len_i = 16'd7;
        cyc();
        start_i = 1'b0;
        lit("report_hold", outs(), {21'd0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd5});

        // Start in the handshake cycle is ignored, next cycle accepted
        res_ready_i = 1'b1; start_i = 1'b1; win_len_i = 16'd40;
        cyc();
        res_ready_i = 1'b0;
        lit("handshake_start_ignored", 32'(busy_o), 32'd0);
        cyc();
        start_i = 1'b0;
        lit("start_after_handshake", 32'(busy_o), 32'd1);

        // Start during COUNT ignored; saturation over 40 toggles
        repeat (3) cyc();
        start_i = 1'b1; win_len_i = 16'd3;
        cyc();
        start_i = 1'b0;
        wait_valid(n);
        lit("sat_rise", 32'(rise_cnt_o), 32'd15);
        lit("sat_fall", 32'(fall_cnt_o), 32'd15);
        lit("sat_ovf", 32'(ovf_o), 32'd1);
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;

        // Zero-length window
        qmode = 0;
        start_i = 1'b1; win_len_i = 16'd0;
        cyc();
        start_i = 1'b0;
        lit("zero_win_report", outs(), {21'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0});
        repeat (5) cyc();
        lit("zero_win_hold", outs(), {21'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0});
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;
        lit("zero_win_idle", 32'(busy_o), 32'd0);

        // Reset in the middle of a window
        qmode = 1;
        start_i = 1'b1; win_len_i = 16'd20;
        cyc();
        start_i = 1'b0;
        repeat (5) cyc();
        #2 reset = 1'b1;
        #1 lit("async_reset", outs(), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (30) cyc();
        lit("no_result_after_reset", {30'd0, busy_o, res_valid_o}, 32'd0);

        // Randomized traffic
        qmode = 2;
        repeat (1500) begin
            start_i     = ($urandom_range(0, 5) == 0);
            win_len_i   = 16'($urandom_range(0, 23));
            res_ready_i = ($urandom_range(0, 2) == 0);
            cyc();
        end
        start_i = 1'b0; res_ready_i = 1'b0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
